// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM encodings, frame constants, scan codes.
package ps2_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_DATA   = 4'b0010,
        ST_PARITY = 4'b0100,
        ST_STOP   = 4'b1000
    } ps2_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0] PS2_SHIFT_CODE = 8'h12;
    localparam logic [7:0] PS2_CTRL_CODE  = 8'h14;

    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_receiver_if.sv
// PS/2 receiver bundle: raw pins, byte stream to the decoder, status flags.
interface ps2_receiver_if;
    import ps2_pkg::*;

    logic       ps2_clk;
    logic       ps2_data;
    logic       rx_ready;
    logic       ovf_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;
    logic       fifo_empty;

    modport master (
        input  ps2_clk, ps2_data, rx_ready, ovf_clr,
        output rx_data, rx_valid, parity_err, frame_err, overflow, fifo_empty
    );

    modport slave (
        output ps2_clk, ps2_data, rx_ready, ovf_clr,
        input  rx_data, rx_valid, parity_err, frame_err, overflow, fifo_empty
    );

endinterface

// File: rtl/ps2_rx_fifo.sv
// Byte FIFO with wrap-bit pointers; a push while full is accepted only alongside a pop.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    output logic       full,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic        w_we;
    logic        w_re;

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_re  = pop & ~empty;
    assign w_we  = push & (~full | w_re);
    assign dout  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_we) r_wptr <= r_wptr + PTR_ONE;
            if (w_re) r_rptr <= r_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 frame deserializer feeding a byte FIFO toward the keyboard decoder.
// Optional PS2_RX_GLITCH_FILTER_EN adds a 4-sample stability filter on ps2_clk.
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    ps2_receiver_if.master bus
);

    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

    logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2, r_clk_prev;
    logic w_clk_lvl, w_fall, w_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_s1   <= bus.ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_dat_s1   <= bus.ps2_data;
            r_dat_s2   <= r_dat_s1;
            r_clk_prev <= w_clk_lvl;
        end
    end

`ifdef PS2_RX_GLITCH_FILTER_EN
    logic       r_clk_filt;
    logic [1:0] r_flt_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_filt <= 1'b1;
            r_flt_cnt  <= '0;
        end else if (r_clk_s2 == r_clk_filt) begin
            r_flt_cnt <= '0;
        end else if (r_flt_cnt == 2'd3) begin
            r_clk_filt <= r_clk_s2;
            r_flt_cnt  <= '0;
        end else begin
            r_flt_cnt <= r_flt_cnt + 2'd1;
        end
    end

    assign w_clk_lvl = r_clk_filt;
`else
    assign w_clk_lvl = r_clk_s2;
`endif

    assign w_fall = r_clk_prev & ~w_clk_lvl;
    assign w_bit  = r_dat_s2;

    ps2_state_e    r_state, w_state_n;
    logic [2:0]    r_cnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [WW-1:0] r_wdog;
    logic          w_timeout, w_push, w_perr, w_ferr;

    assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_wdog == WD_LAST);

    always_comb begin
        w_state_n = r_state;
        w_push    = 1'b0;
        w_perr    = 1'b0;
        w_ferr    = 1'b0;
        if (w_timeout) begin
            w_state_n = ST_IDLE;
            w_ferr    = 1'b1;
        end else if (w_fall) begin
            unique case (r_state)
                ST_IDLE:   if (w_bit == START_BIT) w_state_n = ST_DATA;
                ST_DATA:   if (r_cnt == 3'd7) w_state_n = ST_PARITY;
                ST_PARITY: w_state_n = ST_STOP;
                ST_STOP: begin
                    w_state_n = ST_IDLE;
                    if (w_bit != STOP_BIT)                w_ferr = 1'b1;
                    else if (odd_parity_ok(r_shift, r_par)) w_push = 1'b1;
                    else                                  w_perr = 1'b1;
                end
                default:   w_state_n = ST_IDLE;
            endcase
        end
    end

    logic r_perr, r_ferr, r_ovf, r_valid;
    logic [7:0] r_rx_data;
    logic w_full, w_empty, w_pop, w_drop;
    logic [7:0] w_dout;

    assign w_pop  = ~w_empty & bus.rx_ready;
    assign w_drop = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_wdog    <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_ovf     <= 1'b0;
            r_valid   <= 1'b0;
            r_rx_data <= '0;
        end else begin
            r_state <= w_state_n;
            if (w_fall && r_state == ST_IDLE) r_cnt <= '0;
            if (w_fall && r_state == ST_DATA) begin
                r_shift <= {w_bit, r_shift[7:1]};
                r_cnt   <= r_cnt + 3'd1;
            end
            if (w_fall && r_state == ST_PARITY) r_par <= w_bit;
            // Watchdog only runs while a frame is in flight
            if (w_fall || w_timeout || r_state == ST_IDLE) r_wdog <= '0;
            else                                         r_wdog <= r_wdog + WW'(1);
            r_perr  <= w_perr;
            r_ferr  <= w_ferr;
            if (w_drop)           r_ovf <= 1'b1;
            else if (bus.ovf_clr) r_ovf <= 1'b0;
            r_valid <= w_pop;
            if (w_pop) r_rx_data <= w_dout;
        end
    end

    ps2_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (r_shift),
        .full  (w_full),
        .pop   (w_pop),
        .dout  (w_dout),
        .empty (w_empty)
    );

    assign bus.rx_data    = r_rx_data;
    assign bus.rx_valid   = r_valid;
    assign bus.parity_err = r_perr;
    assign bus.frame_err  = r_ferr;
    assign bus.overflow   = r_ovf;
    assign bus.fifo_empty = w_empty;

endmodule

// File: tb/tb_ps2_receiver.sv
// Randomized PS/2 frame bench with a queue-based delivery model.
module tb_ps2_receiver;

    localparam int DEPTH = 8;
    localparam int TMO   = 300;
    localparam int H     = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ps2_receiver_if bus ();

    ps2_receiver #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_pass = 0;
    int perr_seen = 0, ferr_seen = 0;
    int exp_perr = 0, exp_ferr = 0;
    logic exp_ovf = 1'b0;
    bit hold = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] pend_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus.rx_valid) begin
                if (exp_q.size() == 0) chk("unexp_rx_valid", bus.rx_valid, 0);
                else chk("rx_data", bus.rx_data, exp_q.pop_front());
            end
            if (bus.parity_err) begin
                perr_seen++;
                chk("err_overlap", bus.frame_err, 0);
            end
            if (bus.frame_err) ferr_seen++;
        end
    end

    task automatic drive_bits(input logic [10:0] bits, input int nb);
        for (int i = 0; i < nb; i++) begin
            bus.ps2_data = bits[i];
            repeat (H) @(negedge clk);
            bus.ps2_clk = 1'b0;
            repeat (H) @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
        repeat (H) @(negedge clk);
        bus.ps2_data = 1'b1;
    endtask

    // Reference: what a frame should do, from the frame rules alone
    task automatic model(input logic [7:0] d, input logic par, input logic stp);
        if (!stp) exp_ferr++;
        else if ($countones({d, par}) % 2 == 0) exp_perr++;
        else if (!hold) exp_q.push_back(d);
        else if (pend_q.size() < DEPTH) pend_q.push_back(d);
        else exp_ovf = 1'b1;
    endtask

    task automatic frame(input logic [7:0] d, input logic par_flip, input logic stop_bad);
        logic par, stp;
        par = ($countones(d) % 2 == 0) ^ par_flip;
        stp = ~stop_bad;
        model(d, par, stp);
        drive_bits({stp, par, d, 1'b0}, 11);
        repeat (16) @(negedge clk);
    endtask

    task automatic chk_errs(input string tag);
        chk({tag, "_perr"}, perr_seen, exp_perr);
        chk({tag, "_ferr"}, ferr_seen, exp_ferr);
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        bus.rx_ready = 1'b1;
        bus.ovf_clr  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_perr", bus.parity_err, 0);
        chk("rst_ferr", bus.frame_err, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_empty", bus.fifo_empty, 1);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        frame(8'h1C, 1'b0, 1'b0);
        chk_errs("single");
        chk("single_empty", bus.fifo_empty, 1);

        frame(8'hF0, 1'b0, 1'b0);
        frame(8'h1C, 1'b0, 1'b0);
        chk("hold_rx_data", bus.rx_data, 8'h1C);
        chk("b2b_drained", exp_q.size(), 0);

        frame(8'h12, 1'b1, 1'b0);
        chk_errs("parity");
        frame(8'h12, 1'b0, 1'b1);
        chk_errs("stop");

        exp_ferr++;
        drive_bits({2'b11, 8'h45, 1'b0}, 4);
        repeat (TMO + 20) @(negedge clk);
        chk_errs("timeout");
        frame(8'h45, 1'b0, 1'b0);
        chk("after_tmo_drained", exp_q.size(), 0);

        bus.rx_ready = 1'b0;
        hold = 1'b1;
        for (int i = 1; i <= 8; i++) frame(8'(i), 1'b0, 1'b0);
        chk("ovf_at_full", bus.overflow, exp_ovf);
        frame(8'h09, 1'b0, 1'b0);
        chk("ovf_set", bus.overflow, exp_ovf);
        chk("ovf_not_empty", bus.fifo_empty, 0);
        while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
        hold = 1'b0;
        bus.rx_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("ovf_drained", exp_q.size(), 0);
        chk("ovf_empty", bus.fifo_empty, 1);
        chk("ovf_sticky", bus.overflow, exp_ovf);
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        chk("ovf_clr", bus.overflow, exp_ovf);

        drive_bits({2'b11, 8'hAA, 1'b0}, 6);
        rst = 1'b0;
        #1;
        chk("midrst_rx_data", bus.rx_data, 0);
        chk("midrst_valid", bus.rx_valid, 0);
        chk("midrst_ovf", bus.overflow, 0);
        chk("midrst_empty", bus.fifo_empty, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        frame(8'h16, 1'b0, 1'b0);
        chk("after_rst_drained", exp_q.size(), 0);
        chk_errs("after_rst");

`ifdef PS2_RX_GLITCH_FILTER_EN
        bus.ps2_data = 1'b0;
        repeat (2) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
        bus.ps2_data = 1'b1;
        repeat (20) @(negedge clk);
        frame(8'h5A, 1'b0, 1'b0);
        chk("glitch_drained", exp_q.size(), 0);
        chk_errs("glitch");
`endif

        for (int k = 0; k < 24; k++) begin
            int mode;
            logic [7:0] d;
            mode = $urandom_range(0, 7);
            d = 8'($urandom);
            frame(d, (mode == 0 || mode == 7), (mode >= 6));
        end
        chk("rand_drained", exp_q.size(), 0);
        chk_errs("rand");
        chk("rand_ovf", bus.overflow, exp_ovf);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
